// File: rtl/pe_seq_pkg.sv
// Shared types and helpers for the 1D-convolution PE sequencer.
package pe_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'd0,
    OP_MAC      = 2'd1,
    OP_ADD_PSUM = 2'd2,
    OP_EMIT     = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_ADD,
    S_EMIT,
    S_DONE
  } state_t;

  // Output pixels per row; a zero stride behaves as stride 1.
  function automatic int num_out(input int depth_i, input int depth_f, input int stride);
    int s;
    s = (stride < 1) ? 1 : stride;
    return (depth_i - depth_f) / s + 1;
  endfunction

endpackage

// File: rtl/pe_conv_sequencer_if.sv
// Start/command/done channels between the PE control and the sequencer.
interface pe_conv_sequencer_if #(
  parameter int ADDR_I = 3,
  parameter int ADDR_F = 2
) ();
  logic                  start_valid;
  logic                  start_ready;
  logic                  cmd_valid;
  logic                  cmd_ready;
  pe_seq_pkg::cmd_op_t   cmd_op;
  logic [ADDR_F-1:0]     cmd_filter_addr;
  logic [ADDR_I-1:0]     cmd_ifmap_addr;
  logic [ADDR_I-1:0]     out_idx;
  logic                  done_valid;
  logic                  done_ready;
  logic                  busy;

  modport master (
    input  start_valid, cmd_ready, done_ready,
    output start_ready, cmd_valid, cmd_op, cmd_filter_addr, cmd_ifmap_addr,
           out_idx, done_valid, busy
  );

  modport slave (
    output start_valid, cmd_ready, done_ready,
    input  start_ready, cmd_valid, cmd_op, cmd_filter_addr, cmd_ifmap_addr,
           out_idx, done_valid, busy
  );
endinterface

// File: rtl/pe_seq_addr_gen.sv
// Output/tap counters and ifmap address generation; exposes next-state values
// so the FSM can register its command outputs. Stride input with PE_SEQ_STRIDE_EN.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int DEPTH_I = 5,
  parameter int ADDR_I  = 3,
  parameter int DEPTH_F = 3,
  parameter int ADDR_F  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              start_i,
`ifdef PE_SEQ_STRIDE_EN
  input  logic [1:0]        stride_i,
`endif
  input  logic              step_k_i,
  input  logic              inc_o_i,
  output logic [ADDR_F-1:0] k_d_o,
  output logic [ADDR_I-1:0] o_d_o,
  output logic [ADDR_I-1:0] ifmap_d_o,
  output logic              last_k_o,
  output logic              last_o_o
);
  localparam int AW = ADDR_I + 2;

  logic [ADDR_I-1:0] o_q, o_d;
  logic [ADDR_F-1:0] k_q, k_d;
  logic [1:0]        stride_eff;

`ifdef PE_SEQ_STRIDE_EN
  logic [1:0] stride_q;
  // Stride is frozen at start acceptance for the whole row.
  always_ff @(posedge clk) begin
    if (reset)        stride_q <= 2'd1;
    else if (start_i) stride_q <= (stride_i == 2'd0) ? 2'd1 : stride_i;
  end
  assign stride_eff = stride_q;
`else
  assign stride_eff = 2'd1;
`endif

  assign last_k_o = (int'(k_q) == DEPTH_F - 1);
  assign last_o_o = (int'(o_q) == num_out(DEPTH_I, DEPTH_F, int'(stride_eff)) - 1);

  always_comb begin
    o_d = o_q;
    k_d = k_q;
    if (clr_i) begin
      o_d = '0;
      k_d = '0;
    end else begin
      if (step_k_i) k_d = last_k_o ? '0 : k_q + ADDR_F'(1);
      if (inc_o_i)  o_d = o_q + ADDR_I'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
      k_q <= '0;
    end else begin
      o_q <= o_d;
      k_q <= k_d;
    end
  end

  assign k_d_o     = k_d;
  assign o_d_o     = o_d;
  assign ifmap_d_o = ADDR_I'(AW'(o_d) * AW'(stride_eff) + AW'(k_d));

endmodule

// File: rtl/pe_conv_sequencer.sv
// Row-convolution command sequencer: CLEAR, MACs, ADD_PSUM, EMIT per output pixel.
// Optional PE_SEQ_STRIDE_EN adds a sampled stride input.
module pe_conv_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DEPTH_I = 5,
  parameter int ADDR_I  = 3,
  parameter int DEPTH_F = 3,
  parameter int ADDR_F  = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef PE_SEQ_STRIDE_EN
  input  logic [1:0] stride,
`endif
  pe_conv_sequencer_if.master bus
);
  state_t            state_q;
  logic              cmd_valid_q, done_valid_q, busy_q, start_ready_q;
  cmd_op_t           cmd_op_q;
  logic [ADDR_F-1:0] filter_addr_q;
  logic [ADDR_I-1:0] ifmap_addr_q, out_idx_q;

  logic [ADDR_F-1:0] k_d;
  logic [ADDR_I-1:0] o_d, ifmap_d;
  logic              last_k, last_o;
  logic              fire, start_acc, done_acc;

  assign fire      = cmd_valid_q & bus.cmd_ready;
  assign start_acc = (state_q == S_IDLE) & bus.start_valid;
  assign done_acc  = (state_q == S_DONE) & bus.done_ready;

  pe_seq_addr_gen #(
    .DEPTH_I(DEPTH_I), .ADDR_I(ADDR_I), .DEPTH_F(DEPTH_F), .ADDR_F(ADDR_F)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (start_acc | done_acc),
    .start_i  (start_acc),
`ifdef PE_SEQ_STRIDE_EN
    .stride_i (stride),
`endif
    .step_k_i (fire & (state_q == S_MAC)),
    .inc_o_i  (fire & (state_q == S_EMIT) & ~last_o),
    .k_d_o    (k_d),
    .o_d_o    (o_d),
    .ifmap_d_o(ifmap_d),
    .last_k_o (last_k),
    .last_o_o (last_o)
  );

  // Outputs only change on a transfer, so a stalled command holds steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= OP_CLEAR;
      filter_addr_q <= '0;
      ifmap_addr_q  <= '0;
      out_idx_q     <= '0;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start_valid) begin
          state_q       <= S_CLEAR;
          cmd_valid_q   <= 1'b1;
          cmd_op_q      <= OP_CLEAR;
          out_idx_q     <= '0;
          busy_q        <= 1'b1;
          start_ready_q <= 1'b0;
        end
        S_CLEAR: if (fire) begin
          state_q       <= S_MAC;
          cmd_op_q      <= OP_MAC;
          filter_addr_q <= k_d;
          ifmap_addr_q  <= ifmap_d;
        end
        S_MAC: if (fire) begin
          if (last_k) begin
            state_q       <= S_ADD;
            cmd_op_q      <= OP_ADD_PSUM;
            filter_addr_q <= '0;
            ifmap_addr_q  <= '0;
          end else begin
            filter_addr_q <= k_d;
            ifmap_addr_q  <= ifmap_d;
          end
        end
        S_ADD: if (fire) begin
          state_q  <= S_EMIT;
          cmd_op_q <= OP_EMIT;
        end
        S_EMIT: if (fire) begin
          cmd_op_q <= OP_CLEAR;
          if (last_o) begin
            state_q      <= S_DONE;
            cmd_valid_q  <= 1'b0;
            done_valid_q <= 1'b1;
          end else begin
            state_q   <= S_CLEAR;
            out_idx_q <= o_d;
          end
        end
        S_DONE: if (bus.done_ready) begin
          state_q       <= S_IDLE;
          done_valid_q  <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          out_idx_q     <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready     = start_ready_q;
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_op          = cmd_op_q;
  assign bus.cmd_filter_addr = filter_addr_q;
  assign bus.cmd_ifmap_addr  = ifmap_addr_q;
  assign bus.out_idx         = out_idx_q;
  assign bus.done_valid      = done_valid_q;
  assign bus.busy            = busy_q;

  mac_addr_in_range: assert property (@(posedge clk) disable iff (reset)
    (cmd_valid_q && cmd_op_q == OP_MAC) |-> (int'(ifmap_addr_q) < DEPTH_I));

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Scoreboard bench: a 5/3 sequencer and a 3/3 sequencer share the stimulus.
module tb_pe_conv_sequencer;
  import pe_seq_pkg::*;

  logic clk, reset;
  logic start_v, rdy, dn_rdy, sel;
`ifdef PE_SEQ_STRIDE_EN
  logic [1:0] stride;
`endif
  int n_chk, n_pass, n_fail;
  int cd;
  logic [10:0] q[$];

  pe_conv_sequencer_if #(.ADDR_I(3), .ADDR_F(2)) ba ();
  pe_conv_sequencer_if #(.ADDR_I(2), .ADDR_F(2)) bb ();

  assign ba.start_valid = start_v & ~sel;
  assign bb.start_valid = start_v & sel;
  assign ba.cmd_ready   = rdy;
  assign bb.cmd_ready   = rdy;
  assign ba.done_ready  = dn_rdy;
  assign bb.done_ready  = dn_rdy;

  pe_conv_sequencer #(.DEPTH_I(5), .ADDR_I(3), .DEPTH_F(3), .ADDR_F(2)) dut_a (
    .clk   (clk),
    .reset (reset),
`ifdef PE_SEQ_STRIDE_EN
    .stride(stride),
`endif
    .bus   (ba)
  );

  pe_conv_sequencer #(.DEPTH_I(3), .ADDR_I(2), .DEPTH_F(3), .ADDR_F(2)) dut_b (
    .clk   (clk),
    .reset (reset),
`ifdef PE_SEQ_STRIDE_EN
    .stride(2'd1),
`endif
    .bus   (bb)
  );

  // {valid, op, filter_addr, ifmap_addr, out_idx}
  logic [10:0] obs_cmd;
  logic [2:0]  obs_stat;  // {start_ready, busy, done_valid}
  assign obs_cmd  = sel ? {bb.cmd_valid, bb.cmd_op, bb.cmd_filter_addr, 1'b0, bb.cmd_ifmap_addr, 1'b0, bb.out_idx}
                        : {ba.cmd_valid, ba.cmd_op, ba.cmd_filter_addr, ba.cmd_ifmap_addr, ba.out_idx};
  assign obs_stat = sel ? {bb.start_ready, bb.busy, bb.done_valid}
                        : {ba.start_ready, ba.busy, ba.done_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input cmd_op_t op, input int fa, input int ia, input int oi);
    return {1'b1, op, 2'(fa), 3'(ia), 3'(oi)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input int di, input int df, input int s);
    for (int o = 0; o <= (di - df) / s; o++) begin
      q.push_back(mk(OP_CLEAR, 0, 0, o));
      for (int k = 0; k < df; k++) q.push_back(mk(OP_MAC, k, o * s + k, o));
      q.push_back(mk(OP_ADD_PSUM, 0, 0, o));
      q.push_back(mk(OP_EMIT, 0, 0, o));
    end
  endtask

  // Called at the negedge of cycle 1; cd = cycle in which done_valid shows, -1 on timeout.
  task automatic run(input bit bp, input int budget, output int cdo);
    logic [10:0] prev, cur;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    cdo = -1;
    for (int c = 1; c <= budget; c++) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = obs_cmd;
      if (stalled) chk("stall_stable", cur, prev);
      if (obs_stat[0]) begin
        cdo = c;
        break;
      end
      if (cur[10] && rdy) begin
        if (q.size() == 0) chk("extra_cmd", cur, 11'h0);
        else chk("cmd", cur, q.pop_front());
      end
      stalled = cur[10] && !rdy;
      prev = cur;
      @(negedge clk);
    end
  endtask

  task automatic do_run(input string tag, input bit bp, input bit hold,
                        input int di, input int df, input int s);
    int n, cdl;
    n = (di - df) / s + 1;
    push_row(di, df, s);
    start_v = 1'b1;
    @(negedge clk);
    if (!hold) start_v = 1'b0;
`ifdef PE_SEQ_STRIDE_EN
    stride = 2'd3;
`endif
    chk({tag, "_busy"}, obs_stat, 3'b010);
    run(bp, 400, cdl);
    if (bp) chk({tag, "_done_seen"}, 32'(cdl > 0), 1);
    else    chk({tag, "_done_cyc"}, cdl, n * (df + 3) + 1);
    chk({tag, "_drained"}, q.size(), 0);
    q.delete();
    @(negedge clk);
    chk({tag, "_done_hold"}, {obs_stat, obs_cmd[10]}, 4'b0110);
    dn_rdy = 1'b1;
    @(negedge clk);
    dn_rdy = 1'b0;
    chk({tag, "_idle_stat"}, obs_stat, 3'b100);
    chk({tag, "_idle_cmd"}, obs_cmd, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    reset = 1'b1; start_v = 1'b0; rdy = 1'b0; dn_rdy = 1'b0; sel = 1'b0;
`ifdef PE_SEQ_STRIDE_EN
    stride = 2'd1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_cmd_a", obs_cmd, 0);
    chk("rst_stat_a", obs_stat, 3'b100);
    sel = 1'b1; #1;
    chk("rst_cmd_b", obs_cmd, 0);
    chk("rst_stat_b", obs_stat, 3'b100);
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_run("nominal", 1'b0, 1'b0, 5, 3, 1);
    do_run("backpr", 1'b1, 1'b0, 5, 3, 1);

    // Abort during the second output's MACs.
    push_row(5, 3, 1);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    run(1'b0, 8, cd);
    chk("mid_cmd", obs_cmd, mk(OP_MAC, 1, 2, 1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_stat", obs_stat, 3'b100);
    chk("mid_rst_cmd", obs_cmd, 0);
    q.delete();
    do_run("after_rst", 1'b0, 1'b0, 5, 3, 1);

    // start_valid held through a whole run, then the follow-on run.
    do_run("hold", 1'b0, 1'b1, 5, 3, 1);
    do_run("hold_next", 1'b0, 1'b0, 5, 3, 1);

    sel = 1'b1; #1;
    do_run("single", 1'b0, 1'b0, 3, 3, 1);
    sel = 1'b0; #1;

`ifdef PE_SEQ_STRIDE_EN
    stride = 2'd2;
    do_run("stride2", 1'b0, 1'b0, 5, 3, 2);
    stride = 2'd0;
    do_run("stride0", 1'b0, 1'b0, 5, 3, 1);
    stride = 2'd3;
    do_run("stride3_bp", 1'b1, 1'b0, 5, 3, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
